// File: rtl/ysyx_23060096_lsu_if.sv
// ysyx_23060096_lsu bus bundles.
//   ysyx_23060096_lsu_core_if : core <-> LSU request/response channel
//                               (master = core, slave = LSU).
//   ysyx_23060096_lsu_mem_if  : LSU <-> data memory request/grant/response bus
//                               (master = LSU, slave = memory).
// Both bundles carry the ADDR_W parameter. Data width is fixed at 32.

interface ysyx_23060096_lsu_core_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [2:0]        req_memop;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_wen, req_memop, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_wen, req_memop, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

interface ysyx_23060096_lsu_mem_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060096_lsu.sv
// ysyx_23060096_lsu: load/store unit of the ysyx_23060096 RV32 core.
// Takes one memory operation at a time from the core, runs it on the
// request/grant/response data bus and returns extended load data.
// FSM: IDLE -> REQ -> (WAIT) -> RESP -> IDLE; illegal ops go IDLE -> RESP.
// Every output is a register or a decode of the state register.
// Optional feature: define YSYX_23060096_LSU_MISALIGN_TRAP_EN to flag
// misaligned halfword/word accesses as errors (no bus access). Without it,
// misaligned halfwords use lanes {addr[1],0} and misaligned words lane 0.

module ysyx_23060096_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  ysyx_23060096_lsu_core_if.slave        core,
  ysyx_23060096_lsu_mem_if.master        mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;

  // Accept-time decode
  logic              accept;
  logic [1:0]        req_off;
  logic              memop_legal;
  logic              acc_err;
  logic [1:0]        lane;
  logic [3:0]        wstrb_n;
  logic [31:0]       wdata_n;
`ifdef YSYX_23060096_LSU_MISALIGN_TRAP_EN
  logic              misalign;
`endif

  // Latched operation
  logic [2:0]        memop_q;
  logic [1:0]        lane_q;
  logic              err_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       rdata_q;

  // Load extraction
  logic [31:0]       rd_shifted;
  logic [31:0]       load_ext;

  assign accept  = (state == IDLE) && core.req_valid;
  assign req_off = core.req_addr[1:0];

  // MemOP legality: loads allow B/H/W/BU/HU, stores only B/H/W.
  always_comb begin
    memop_legal = 1'b0;
    case (core.req_memop)
      3'b000, 3'b001, 3'b010: memop_legal = 1'b1;
      3'b100, 3'b101:         memop_legal = ~core.req_wen;
      default:                memop_legal = 1'b0;
    endcase
  end

`ifdef YSYX_23060096_LSU_MISALIGN_TRAP_EN
  // Misaligned halfword (addr[0]) or word (addr[1:0] != 0) is trapped.
  always_comb begin
    misalign = 1'b0;
    case (core.req_memop[1:0])
      2'b01:   misalign = req_off[0];
      2'b10:   misalign = (req_off != 2'b00);
      default: misalign = 1'b0;
    endcase
    acc_err = ~memop_legal | misalign;
  end
`else
  // Only illegal MemOP encodings are errors.
  always_comb begin
    acc_err = ~memop_legal;
  end
`endif

  // Byte-lane offset: halfwords snap to {addr[1],0}, words to lane 0.
  // With the trap enabled these only differ for accesses that error out.
  always_comb begin
    lane = req_off;
    case (core.req_memop[1:0])
      2'b00:   lane = req_off;
      2'b01:   lane = {req_off[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  // Store byte enables and lane-shifted store data; loads have no strobes.
  always_comb begin
    wstrb_n = 4'b0000;
    if (core.req_wen) begin
      case (core.req_memop[1:0])
        2'b00:   wstrb_n = 4'b0001 << lane;
        2'b01:   wstrb_n = 4'b0011 << lane;
        default: wstrb_n = 4'b1111;
      endcase
    end
    wdata_n = core.req_wdata << {lane, 3'b000};
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (core.req_valid) state_n = acc_err ? RESP : REQ;
      REQ:  if (mem.mem_gnt)    state_n = mem_we_q ? RESP : WAIT;
      WAIT: if (mem.mem_rvalid) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Select the addressed byte/halfword and extend it (word uses lane 0).
  always_comb begin
    rd_shifted = mem.mem_rdata >> {lane_q, 3'b000};
    case (memop_q[1:0])
      2'b00:   load_ext = {{24{~memop_q[2] & rd_shifted[7]}},  rd_shifted[7:0]};
      2'b01:   load_ext = {{16{~memop_q[2] & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  // Operation latch, bus fields, and response data/error registers.
  // Response registers are cleared on leaving RESP so they read 0 otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      memop_q     <= '0;
      lane_q      <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        memop_q <= core.req_memop;
        lane_q  <= lane;
        err_q   <= acc_err;
        if (!acc_err) begin
          mem_we_q    <= core.req_wen;
          mem_addr_q  <= {core.req_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_q <= wdata_n;
          mem_wstrb_q <= wstrb_n;
        end
      end
      if ((state == WAIT) && mem.mem_rvalid) begin
        rdata_q <= load_ext;
      end
      if (state == RESP) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign core.req_ready  = (state == IDLE);
  assign core.busy       = (state != IDLE);
  assign core.resp_valid = (state == RESP);
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

  assign mem.mem_req     = (state == REQ);
  assign mem.mem_we      = mem_we_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_wdata   = mem_wdata_q;
  assign mem.mem_wstrb   = mem_wstrb_q;

endmodule

// File: tb/tb_ysyx_23060096_lsu.sv
// tb_ysyx_23060096_lsu: directed + randomized bench for ysyx_23060096_lsu.
// Expected values come from an arithmetic model of the MemOP rules.
// Follows YSYX_23060096_LSU_MISALIGN_TRAP_EN when it is defined.

module tb_ysyx_23060096_lsu;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060096_lsu_core_if #(.ADDR_W(32)) core_if ();
  ysyx_23060096_lsu_mem_if  #(.ADDR_W(32)) mem_if ();

  ysyx_23060096_lsu #(.ADDR_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .core (core_if),
    .mem  (mem_if)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: size in bytes, lane offset, masks and sign bit by arithmetic.
  function automatic exp_t model(input logic wen, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rword);
    exp_t        e;
    int unsigned size;
    int unsigned lane;
    logic        legal;
    logic        mis;
    logic [31:0] mask;
    logic [31:0] v;
    size  = 1 << op[1:0];
    legal = wen ? (op <= 3'd2) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0);
`ifdef YSYX_23060096_LSU_MISALIGN_TRAP_EN
    e.err = !legal || mis;
`else
    e.err = !legal || (mis && 1'b0);
`endif
    lane = addr % 4;
    if (size == 2) lane = (lane / 2) * 2;
    if (size >= 4) lane = 0;
    e.addr  = addr - (addr % 4);
    e.wstrb = wen ? 4'(((1 << size) - 1) << lane) : 4'd0;
    e.wdata = wdata << (8 * lane);
    mask    = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v       = (rword >> (8 * lane)) & mask;
    if (!op[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    e.rdata = (wen || e.err) ? 32'd0 : v;
    return e;
  endfunction

  // One operation: accept, grant after gdly, rvalid after rdly, check each cycle.
  task automatic do_op(input string tag, input logic wen, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rword, input int gdly, input int rdly,
                       output logic [31:0] rdata_seen);
    exp_t e;
    e = model(wen, op, addr, wdata, rword);
    rdata_seen = 32'hDEAD_DEAD;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(core_if.req_ready), 32'd1);
    core_if.req_valid = 1'b1;
    core_if.req_wen   = wen;
    core_if.req_memop = op;
    core_if.req_addr  = addr;
    core_if.req_wdata = wdata;
    @(negedge clk);
    core_if.req_valid = 1'b0;
    core_if.req_wen   = 1'($urandom);
    core_if.req_memop = 3'($urandom);
    core_if.req_addr  = $urandom;
    core_if.req_wdata = $urandom;
    chk({tag, ".busy"}, 32'(core_if.busy), 32'd1);
    if (e.err) begin
      chk({tag, ".err_valid"}, 32'(core_if.resp_valid), 32'd1);
      chk({tag, ".err_flag"}, 32'(core_if.resp_err), 32'd1);
      chk({tag, ".err_rdata"}, core_if.resp_rdata, 32'd0);
      chk({tag, ".err_nobus"}, 32'(mem_if.mem_req), 32'd0);
      rdata_seen = core_if.resp_rdata;
    end else begin
      for (int i = 0; i <= gdly; i++) begin
        chk({tag, ".mem_req"}, 32'(mem_if.mem_req), 32'd1);
        chk({tag, ".mem_addr"}, mem_if.mem_addr, e.addr);
        chk({tag, ".mem_we"}, 32'(mem_if.mem_we), 32'(wen));
        chk({tag, ".mem_wstrb"}, 32'(mem_if.mem_wstrb), 32'(e.wstrb));
        if (wen) chk({tag, ".mem_wdata"}, mem_if.mem_wdata, e.wdata);
        chk({tag, ".busy_req"}, 32'(core_if.busy), 32'd1);
        mem_if.mem_gnt = (i == gdly);
        @(negedge clk);
        mem_if.mem_gnt = 1'b0;
      end
      if (!wen) begin
        for (int j = 0; j <= rdly; j++) begin
          chk({tag, ".wait_noreq"}, 32'(mem_if.mem_req), 32'd0);
          chk({tag, ".wait_novalid"}, 32'(core_if.resp_valid), 32'd0);
          mem_if.mem_rvalid = (j == rdly);
          mem_if.mem_rdata  = (j == rdly) ? rword : $urandom;
          @(negedge clk);
          mem_if.mem_rvalid = 1'b0;
          mem_if.mem_rdata  = $urandom;
        end
      end
      chk({tag, ".resp_valid"}, 32'(core_if.resp_valid), 32'd1);
      chk({tag, ".resp_err"}, 32'(core_if.resp_err), 32'd0);
      chk({tag, ".resp_rdata"}, core_if.resp_rdata, e.rdata);
      chk({tag, ".resp_noreq"}, 32'(mem_if.mem_req), 32'd0);
      rdata_seen = core_if.resp_rdata;
    end
    @(negedge clk);
    chk({tag, ".done_valid"}, 32'(core_if.resp_valid), 32'd0);
    chk({tag, ".done_ready"}, 32'(core_if.req_ready), 32'd1);
    chk({tag, ".done_busy"}, 32'(core_if.busy), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ready"}, 32'(core_if.req_ready), 32'd1);
    chk({tag, ".busy"}, 32'(core_if.busy), 32'd0);
    chk({tag, ".resp_valid"}, 32'(core_if.resp_valid), 32'd0);
    chk({tag, ".resp_rdata"}, core_if.resp_rdata, 32'd0);
    chk({tag, ".resp_err"}, 32'(core_if.resp_err), 32'd0);
    chk({tag, ".mem_req"}, 32'(mem_if.mem_req), 32'd0);
    chk({tag, ".mem_we"}, 32'(mem_if.mem_we), 32'd0);
    chk({tag, ".mem_addr"}, mem_if.mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_if.mem_wdata, 32'd0);
    chk({tag, ".mem_wstrb"}, 32'(mem_if.mem_wstrb), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    rstn              = 1'b0;
    core_if.req_valid = 1'b0;
    core_if.req_wen   = 1'b0;
    core_if.req_memop = 3'd0;
    core_if.req_addr  = '0;
    core_if.req_wdata = '0;
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    rstn = 1'b1;

    // Directed steps
    do_op("lb", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, rd);
    chk("lb.value", rd, 32'hFFFF_FF80);
    do_op("lhu", 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 0, rd);
    chk("lhu.value", rd, 32'h0000_BEEF);
    do_op("lh", 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 1, 2, rd);
    chk("lh.value", rd, 32'hFFFF_BEEF);
    do_op("sb", 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 3, 0, rd);
    chk("sb.rdata", rd, 32'd0);
    do_op("lw_mis", 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1234_5678, 0, 0, rd);
`ifdef YSYX_23060096_LSU_MISALIGN_TRAP_EN
    chk("lw_mis.value", rd, 32'd0);
`else
    chk("lw_mis.value", rd, 32'h1234_5678);
`endif
    do_op("ld011", 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, rd);
    do_op("st100", 1'b1, 3'b100, 32'h8000_0000, 32'h55, 32'h0, 0, 0, rd);
    do_op("sh", 1'b1, 3'b001, 32'h8000_0006, 32'h0000_CAFE, 32'h0, 2, 0, rd);
    do_op("sw", 1'b1, 3'b010, 32'h8000_0008, 32'h1357_9BDF, 32'h0, 0, 0, rd);
    do_op("lbu", 1'b0, 3'b100, 32'h8000_0001, 32'h0, 32'h1122_9F44, 0, 3, rd);
    chk("lbu.value", rd, 32'h0000_009F);

    // Reset while waiting for load data; the late rvalid must be dropped.
    @(negedge clk);
    core_if.req_valid = 1'b1;
    core_if.req_wen   = 1'b0;
    core_if.req_memop = 3'b010;
    core_if.req_addr  = 32'h8000_0010;
    core_if.req_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    core_if.req_valid = 1'b0;
    mem_if.mem_gnt    = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    chk("abort.in_wait_busy", 32'(core_if.busy), 32'd1);
    chk("abort.in_wait_noreq", 32'(mem_if.mem_req), 32'd0);
    #2 rstn = 1'b0;
    #1 chk_reset_state("abort");
    @(negedge clk);
    rstn = 1'b1;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort.late_rvalid", 32'(core_if.resp_valid), 32'd0);
      chk("abort.idle", 32'(core_if.busy), 32'd0);
    end
    mem_if.mem_rvalid = 1'b0;
    do_op("lw_after", 1'b0, 3'b010, 32'h8000_0014, 32'h0, 32'h0BAD_F00D, 0, 0, rd);
    chk("lw_after.value", rd, 32'h0BAD_F00D);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      do_op("rnd", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
